display_rx: RTL and testbench



---
 rtl/display_pkg.sv | 15 +
 rtl/sync_edge.sv | 32 +++
 rtl/display_rx.sv | 138 +++++++++++++
 tb/tb_display_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and FSM encoding for the front-panel display link.
// Used by both the receiver and the display transmitter.
package display_pkg;

  localparam int DISPLAY_NBITS       = 72;
  localparam int DISPLAY_SYNC_STAGES = 2;
  localparam int DISPLAY_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } disp_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchroniser with rise/fall detection.
// Reset value is a parameter so active-low inputs can idle high.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/display_rx.sv
// Receive end of the front-panel display serial link: oversamples the
// link, deserialises into an NBITS shift register, latches on sload.
module display_rx
  import display_pkg::*;
#(
  parameter int NBITS       = DISPLAY_NBITS,
  parameter int SYNC_STAGES = DISPLAY_SYNC_STAGES,
  parameter int CNT_W       = DISPLAY_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             sdata_in,
  input  logic             sload_in,
  input  logic             sclr_n_in,
  output logic [NBITS-1:0] frame_out,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy
);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_sdata, w_sdata_rise, w_sdata_fall;
  logic w_load_lvl, w_load_rise, w_load_fall;
  logic w_clr_n, w_clr_rise, w_clr_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(sclk_in),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata (
    .clk(clk), .rst_n(rst_n), .i_d(sdata_in),
    .o_level(w_sdata), .o_rise(w_sdata_rise), .o_fall(w_sdata_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sload (
    .clk(clk), .rst_n(rst_n), .i_d(sload_in),
    .o_level(w_load_lvl), .o_rise(w_load_rise), .o_fall(w_load_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclr (
    .clk(clk), .rst_n(rst_n), .i_d(sclr_n_in),
    .o_level(w_clr_n), .o_rise(w_clr_rise), .o_fall(w_clr_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sclk_lvl, w_sclk_fall, w_sdata_rise, w_sdata_fall,
                      w_load_lvl, w_load_fall, w_clr_rise, w_clr_fall};

  disp_state_e      r_state;
  logic [NBITS-1:0] r_sr;
  logic [NBITS-1:0] r_snap;
  logic             r_snap_err;
  logic [CNT_W-1:0] r_cnt;
  logic [NBITS-1:0] r_frame;
  logic             r_valid;
  logic             r_err;

  logic             w_clr;
  logic             w_sh;
  logic [NBITS-1:0] w_sr_sh;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_at_load;

  // Clear beats a coincident shift; the dropped bit is never counted.
  assign w_clr         = ~w_clr_n;
  assign w_sh          = w_sclk_rise & w_clr_n;
  assign w_sr_sh       = {r_sr[NBITS-2:0], w_sdata};
  assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_at_load = w_sh ? w_cnt_inc : r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_snap     <= '0;
      r_snap_err <= 1'b0;
      r_cnt      <= '0;
      r_frame    <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_clr) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else if (w_sh) begin
        r_sr  <= w_sr_sh;
        r_cnt <= w_cnt_inc;
      end

      // Snapshot includes a coincident shift but precedes a coincident clear.
      if (w_load_rise) begin
        r_snap     <= w_sh ? w_sr_sh : r_sr;
        r_snap_err <= (w_cnt_at_load != CNT_W'(NBITS));
        r_cnt      <= '0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_load_rise)
            r_state <= LATCH;
          else if (w_sh)
            r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_load_rise)
            r_state <= LATCH;
          else if (w_clr)
            r_state <= IDLE;
        end
        LATCH: begin
          r_frame <= r_snap;
          r_valid <= 1'b1;
          r_err   <= r_snap_err;
          if (w_load_rise)
            r_state <= LATCH;
          else if (w_sh)
            r_state <= SHIFT;
          else
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign frame_out   = r_frame;
  assign frame_valid = r_valid;
  assign frame_err   = r_err;
  assign bit_count   = r_cnt;
  assign busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_display_rx.sv
// Randomised bench for display_rx against a bit-level frame model.
// Model tracks received bits and count per transaction, not per cycle.
module tb_display_rx;
  import display_pkg::*;

  localparam int NB  = DISPLAY_NBITS;
  localparam int SS  = DISPLAY_SYNC_STAGES;
  localparam int CW  = DISPLAY_CNT_W;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          sdata = 1'b0;
  logic          sload = 1'b0;
  logic          sclr_n = 1'b1;
  logic [NB-1:0] frame_out;
  logic          frame_valid;
  logic          frame_err;
  logic [CW-1:0] bit_count;
  logic          busy;

  display_rx dut (
    .clk(clk), .rst_n(rst_n),
    .sclk_in(sclk), .sdata_in(sdata),
    .sload_in(sload), .sclr_n_in(sclr_n),
    .frame_out(frame_out), .frame_valid(frame_valid),
    .frame_err(frame_err), .bit_count(bit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            vcnt = 0;
  logic [NB-1:0] cap_frame = '0;
  logic          cap_err = 1'b0;
  logic [NB-1:0] m_sr = '0;
  int            m_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) begin
      vcnt++;
      cap_frame = frame_out;
      cap_err = frame_err;
    end
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_bit(input logic b);
    m_sr = {m_sr[NB-2:0], b};
    if (m_cnt < SAT) m_cnt++;
  endtask

  task automatic send_bit(input logic b, input int half);
    @(negedge clk);
    sdata = b;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
    model_bit(b);
  endtask

  task automatic send_vec(input logic [NB-1:0] v, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], half);
  endtask

  task automatic send_rand(input int n, input int half);
    for (int i = 0; i < n; i++) send_bit(1'($urandom), half);
  endtask

  task automatic do_clear();
    @(negedge clk);
    sclr_n = 1'b0;
    repeat (4) @(negedge clk);
    sclr_n = 1'b1;
    repeat (4) @(negedge clk);
    m_sr = '0;
    m_cnt = 0;
    check("clr_cnt", 128'(bit_count), 128'd0);
    check("clr_busy", 128'(busy), 128'd0);
  endtask

  // Raises sload (optionally together with one final sclk rise) and
  // checks latency, pulse count, latched frame and error flag.
  task automatic do_latch(input string tag, input bit with_bit,
                          input logic b, input int half);
    int            v0;
    int            lat;
    logic [NB-1:0] e_fr;
    logic          e_err;
    v0 = vcnt;
    lat = 0;
    @(negedge clk);
    if (with_bit) begin
      sdata = b;
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      model_bit(b);
    end
    sload = 1'b1;
    e_fr = m_sr;
    e_err = (m_cnt != NB);
    m_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (frame_valid && lat == 0) lat = i;
      if (i == 5) begin
        sload = 1'b0;
        sclk = 1'b0;
      end
    end
    check({tag, "_lat"}, 128'(lat), 128'(SS + 2));
    check({tag, "_npulse"}, 128'(vcnt - v0), 128'd1);
    check({tag, "_frame"}, 128'(cap_frame), 128'(e_fr));
    check({tag, "_err"}, 128'(cap_err), 128'(e_err));
    check({tag, "_cnt"}, 128'(bit_count), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int v0;
    int len;
    int half;
    logic [NB-1:0] tmp;

    repeat (3) @(negedge clk);
    check("rst_frame", 128'(frame_out), 128'd0);
    check("rst_valid", 128'(frame_valid), 128'd0);
    check("rst_err", 128'(frame_err), 128'd0);
    check("rst_cnt", 128'(bit_count), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_vec(72'hA5_0123456789ABCDEF, NB, 16);
    check("full_cnt", 128'(bit_count), 128'(NB));
    check("full_busy", 128'(busy), 128'd1);
    do_latch("full", 1'b0, 1'b0, 16);
    check("full_abs", 128'(cap_frame), 128'(72'hA5_0123456789ABCDEF));

    send_rand(70, 4);
    do_latch("short70", 1'b0, 1'b0, 4);

    send_rand(36, 4);
    do_clear();
    send_vec({NB{1'b1}}, NB, 4);
    do_latch("clr_ones", 1'b0, 1'b0, 4);
    check("clr_ones_abs", 128'(cap_frame), 128'({NB{1'b1}}));

    tmp = {$urandom, $urandom, $urandom};
    send_vec(tmp >> 1, NB - 1, 5);
    do_latch("coinc", 1'b1, tmp[0], 5);
    check("coinc_abs", 128'(cap_frame), 128'(tmp));

    send_rand(40, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_frame", 128'(frame_out), 128'd0);
    check("mid_rst_valid", 128'(frame_valid), 128'd0);
    check("mid_rst_cnt", 128'(bit_count), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_sr = '0;
    m_cnt = 0;
    v0 = vcnt;
    repeat (10) @(negedge clk);
    check("mid_rst_nopulse", 128'(vcnt - v0), 128'd0);
    send_rand(NB, 4);
    do_latch("post_rst", 1'b0, 1'b0, 4);

    send_rand(300, 3);
    check("sat_cnt", 128'(bit_count), 128'(SAT));
    do_latch("sat", 1'b0, 1'b0, 3);

    do_latch("idle_load", 1'b0, 1'b0, 3);

    for (int k = 0; k < 8; k++) begin
      len = (k % 3 == 0) ? NB : int'($urandom_range(0, 90));
      half = int'($urandom_range(3, 7));
      send_rand(len, half);
      if ($urandom_range(0, 3) == 0) begin
        do_clear();
        send_rand(int'($urandom_range(0, 80)), half);
      end
      do_latch($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
               1'($urandom), half);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
